// File: rtl/snd_latch_irq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// snd_latch_irq: sound-CPU command FIFO, Z80 INT/RST-vector merge, I/O ports
// Rev 1.0
// ---------------------------------------------------------------------------
module snd_latch_irq #(
  parameter int         DEPTH       = 4,
  parameter logic [7:0] LATCH_PORT  = 8'h02,
  parameter logic [7:0] ACK_PORT    = 8'h06,
  parameter logic [7:0] STATUS_PORT = 8'h04
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       latch_wr,
  input  logic [7:0] latch_din,
  input  logic       z80_ce,
  input  logic       io_rd,
  input  logic       io_wr,
  input  logic [7:0] io_addr,
  input  logic [7:0] io_din,
  output logic [7:0] io_dout,
  input  logic       intack,
  output logic [7:0] vector,
  output logic       int_n,
  input  logic       ym_irq_n,
  output logic       pending
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               CNT_W    = $clog2(DEPTH) + 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overrun_q, overrun_d;
  logic             ym_q, ym_d;
  logic             int_n_q, int_n_d;
  logic [7:0]       vec_hold_q, vec_hold_d;
  logic             latch_wr_q, latch_wr_d;
  logic             ack_q, ack_d;
  logic             st_q, st_d;
  logic             intack_q, intack_d;

  logic       ack_c, st_c, push, pop, push_ok, full;
  logic [7:0] raw, head, status, cnt_ext;
  logic       unused_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign ack_c   = z80_ce & io_wr & (io_addr == ACK_PORT);
  assign st_c    = z80_ce & io_rd & (io_addr == STATUS_PORT);
  assign full    = (count_q == CNT_FULL);
  assign push    = latch_wr & ~latch_wr_q;
  assign pop     = ack_c & ~ack_q & (count_q != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push_ok = push & (~full | pop);

  assign cnt_ext = 8'(count_q);
  assign head    = (count_q == '0) ? 8'hFF : mem_q[rd_ptr_q];
  assign status  = {overrun_q, ~ym_q, 2'b00, cnt_ext[3:0]};
  assign raw     = {2'b11, ~pending, ym_q, 4'hF};

  always_comb begin
    latch_wr_d = latch_wr;
    ack_d      = ack_c;
    st_d       = st_c;
    intack_d   = intack;
    ym_d       = ym_irq_n;
    wr_ptr_d   = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d    = count_q;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push_ok) count_d = count_q - 1'b1;
    overrun_d  = overrun_q;
    if (st_q && !st_c)        overrun_d = 1'b0;
    if (push && !push_ok)     overrun_d = 1'b1;
    int_n_d    = (raw == 8'hFF);
    vec_hold_d = (intack && !intack_q) ? raw : vec_hold_q;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      ym_q       <= 1'b1;
      int_n_q    <= 1'b1;
      vec_hold_q <= 8'hFF;
      latch_wr_q <= 1'b0;
      ack_q      <= 1'b0;
      st_q       <= 1'b0;
      intack_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      ym_q       <= ym_d;
      int_n_q    <= int_n_d;
      vec_hold_q <= vec_hold_d;
      latch_wr_q <= latch_wr_d;
      ack_q      <= ack_d;
      st_q       <= st_d;
      intack_q   <= intack_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push_ok) mem_q[wr_ptr_q] <= latch_din;
  end

  assign pending = (count_q != '0);
  assign int_n   = int_n_q;
  // First intack cycle shows the live vector; afterwards the captured copy is held.
  assign vector  = intack ? (intack_q ? vec_hold_q : raw) : 8'hFF;

  always_comb begin
    io_dout = 8'hFF;
    if (io_rd && io_addr == LATCH_PORT)       io_dout = head;
    else if (io_rd && io_addr == STATUS_PORT) io_dout = status;
  end

  assign unused_ok = ^{io_din, cnt_ext[7:4]};

endmodule
`default_nettype wire

// File: tb/tb_snd_latch_irq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_snd_latch_irq: directed table, corner sequences and random vs. model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_snd_latch_irq;

  localparam int DEPTH = 4;

  logic       clk_sys = 1'b0;
  logic       reset_n, latch_wr, z80_ce, io_rd, io_wr, intack, ym_irq_n;
  logic [7:0] latch_din, io_addr, io_din;
  logic [7:0] io_dout, vector;
  logic       int_n, pending;

  int checks = 0;
  int failures = 0;

  snd_latch_irq #(.DEPTH(DEPTH)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .latch_wr(latch_wr), .latch_din(latch_din),
    .z80_ce(z80_ce), .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr), .io_din(io_din),
    .io_dout(io_dout), .intack(intack), .vector(vector), .int_n(int_n),
    .ym_irq_n(ym_irq_n), .pending(pending)
  );

  always #5 clk_sys = ~clk_sys;

  // Behavioural model: byte queue plus a few flags, advanced once per clock edge.
  logic [7:0] mq[$];
  logic       m_ov = 1'b0, m_ym = 1'b1, m_int_n = 1'b1;
  logic [7:0] m_hold = 8'hFF;
  logic       p_wr = 1'b0, p_ack = 1'b0, p_st = 1'b0, p_intack = 1'b0;

  function automatic logic [7:0] m_raw();
    logic [7:0] r = 8'hFF;
    if (mq.size() != 0) r[5] = 1'b0;
    if (!m_ym)          r[4] = 1'b0;
    return r;
  endfunction

  function automatic logic [7:0] m_status();
    return {m_ov, ~m_ym, 2'b00, 4'(mq.size())};
  endfunction

  function automatic logic [7:0] m_dout();
    if (io_rd && io_addr == 8'h02) return (mq.size() != 0) ? mq[0] : 8'hFF;
    if (io_rd && io_addr == 8'h04) return m_status();
    return 8'hFF;
  endfunction

  function automatic logic [7:0] m_vector();
    if (!intack) return 8'hFF;
    return p_intack ? m_hold : m_raw();
  endfunction

  task automatic model_step();
    logic       ack, st, do_pop, do_push;
    logic [7:0] r;
    if (!reset_n) begin
      mq.delete();
      m_ov = 1'b0; m_ym = 1'b1; m_int_n = 1'b1; m_hold = 8'hFF;
      p_wr = 1'b0; p_ack = 1'b0; p_st = 1'b0; p_intack = 1'b0;
    end else begin
      r       = m_raw();
      ack     = z80_ce && io_wr && io_addr == 8'h06;
      st      = z80_ce && io_rd && io_addr == 8'h04;
      do_pop  = ack && !p_ack && mq.size() != 0;
      do_push = latch_wr && !p_wr;
      m_int_n = (r == 8'hFF);
      if (intack && !p_intack) m_hold = r;
      if (p_st && !st) m_ov = 1'b0;
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        if (mq.size() == DEPTH) m_ov = 1'b1;
        else mq.push_back(latch_din);
      end
      m_ym = ym_irq_n;
      p_wr = latch_wr; p_ack = ack; p_st = st; p_intack = intack;
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    model_step();
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    latch_wr = 1'b1; latch_din = b; tick();
    latch_wr = 1'b0; tick();
  endtask

  task automatic ack();
    io_wr = 1'b1; io_addr = 8'h06; tick();
    io_wr = 1'b0; tick();
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] v);
    io_rd = 1'b1; io_addr = a; #1;
    v = io_dout;
    tick();
    io_rd = 1'b0; tick();
  endtask

  task automatic intack_chk(input string nm, input logic [7:0] exp);
    intack = 1'b1; tick();
    chk(nm, vector, exp);
    intack = 1'b0; tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0; tick();
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic       rst_n, wr;
    logic [7:0] din;
    logic       rd, iow;
    logic [7:0] addr;
    logic       iack;
    logic       e_int_n;
    logic [7:0] e_vec;
    logic       e_pend;
    logic [7:0] e_dout;
  } vec_t;

  vec_t       tbl[8];
  logic [7:0] v;
  logic [7:0] exp5[4];

  initial begin
    reset_n = 1'b0; latch_wr = 1'b0; latch_din = 8'h00; z80_ce = 1'b1;
    io_rd = 1'b0; io_wr = 1'b0; io_addr = 8'h00; io_din = 8'h00;
    intack = 1'b0; ym_irq_n = 1'b1;

    // Single command round trip, one record per clock.
    tbl[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0, 8'hFF};
    tbl[1] = '{1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b1, 8'hFF};
    tbl[2] = '{1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 8'hFF};
    tbl[3] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hDF, 1'b1, 8'hFF};
    tbl[4] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h02, 1'b0, 1'b0, 8'hFF, 1'b1, 8'h5A};
    tbl[5] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h06, 1'b0, 1'b0, 8'hFF, 1'b0, 8'hFF};
    tbl[6] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0, 8'hFF};
    tbl[7] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h04, 1'b0, 1'b1, 8'hFF, 1'b0, 8'h00};
    for (int i = 0; i < 8; i++) begin
      reset_n = tbl[i].rst_n; latch_wr = tbl[i].wr; latch_din = tbl[i].din;
      io_rd = tbl[i].rd; io_wr = tbl[i].iow; io_addr = tbl[i].addr; intack = tbl[i].iack;
      tick();
      chk($sformatf("tbl%0d_int_n", i), {7'b0, int_n}, {7'b0, tbl[i].e_int_n});
      chk($sformatf("tbl%0d_vector", i), vector, tbl[i].e_vec);
      chk($sformatf("tbl%0d_pending", i), {7'b0, pending}, {7'b0, tbl[i].e_pend});
      chk($sformatf("tbl%0d_dout", i), io_dout, tbl[i].e_dout);
    end
    io_rd = 1'b0; tick();

    // Long strobe pushes once.
    latch_wr = 1'b1; latch_din = 8'h11;
    for (int i = 0; i < 10; i++) tick();
    latch_wr = 1'b0; tick();
    rd(8'h04, v); chk("long_strobe_status", v, 8'h01);
    rd(8'h02, v); chk("long_strobe_head", v, 8'h11);
    ack();

    // Overflow, drain order, overrun clear.
    for (int i = 1; i <= 5; i++) push(8'(i));
    rd(8'h04, v); chk("overrun_status", v, 8'h84);
    for (int i = 1; i <= 4; i++) begin
      rd(8'h02, v); chk($sformatf("drain%0d", i), v, 8'(i));
      ack();
    end
    rd(8'h02, v); chk("drain_empty", v, 8'hFF);
    rd(8'h04, v); chk("overrun_cleared", v, 8'h00);

    // Vector merging and hold during intack.
    ym_irq_n = 1'b0; tick(); tick();
    chk("ym_int_n", {7'b0, int_n}, 8'h00);
    intack_chk("vec_ym", 8'hEF);
    push(8'hAA);
    intack_chk("vec_both", 8'hCF);
    ym_irq_n = 1'b1; tick(); tick();
    intack_chk("vec_latch", 8'hDF);
    intack = 1'b1; tick();
    chk("vec_hold0", vector, 8'hDF);
    ym_irq_n = 1'b0; tick(); tick();
    chk("vec_hold_ym", vector, 8'hDF);
    push(8'hBB);
    chk("vec_hold_push", vector, 8'hDF);
    ym_irq_n = 1'b1; intack = 1'b0; tick();
    chk("vec_idle", vector, 8'hFF);
    ack(); ack(); tick();
    chk("vec_int_clear", {7'b0, int_n}, 8'h01);

    // Full FIFO: push and ack on the same clock.
    do_reset();
    for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
    latch_wr = 1'b1; latch_din = 8'hB4; io_wr = 1'b1; io_addr = 8'h06; tick();
    latch_wr = 1'b0; io_wr = 1'b0; tick();
    rd(8'h04, v); chk("full_pushpop_status", v, 8'h04);
    exp5 = '{8'hA1, 8'hA2, 8'hA3, 8'hB4};
    for (int i = 0; i < 4; i++) begin
      rd(8'h02, v); chk($sformatf("full_pushpop_head%0d", i), v, exp5[i]);
      ack();
    end

    // Reset while busy.
    push(8'h31); push(8'h32); push(8'h33);
    chk("busy_int_n", {7'b0, int_n}, 8'h00);
    do_reset();
    chk("rst_int_n", {7'b0, int_n}, 8'h01);
    chk("rst_pending", {7'b0, pending}, 8'h00);
    rd(8'h04, v); chk("rst_status", v, 8'h00);
    rd(8'h02, v); chk("rst_latch", v, 8'hFF);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset_n   = ($urandom_range(0, 299) != 0);
      latch_wr  = ($urandom_range(0, 2) == 0);
      latch_din = 8'($urandom);
      z80_ce    = ($urandom_range(0, 4) != 0);
      io_rd     = ($urandom_range(0, 2) == 0);
      io_wr     = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0: io_addr = 8'h02;
        1: io_addr = 8'h04;
        2: io_addr = 8'h06;
        default: io_addr = 8'($urandom);
      endcase
      io_din = 8'($urandom);
      if ($urandom_range(0, 3) == 0) intack = ~intack;
      if ($urandom_range(0, 7) == 0) ym_irq_n = ~ym_irq_n;
      tick();
      chk("rnd_int_n", {7'b0, int_n}, {7'b0, m_int_n});
      chk("rnd_pending", {7'b0, pending}, {7'b0, mq.size() != 0});
      chk("rnd_vector", vector, m_vector());
      chk("rnd_dout", io_dout, m_dout());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
